// File: rtl/i2c.sv
// Single-byte I2C master: start, 7-bit address, R/W, ACK, one data byte, ACK/NACK, stop.
// Each bit slot is two clk cycles (scl low then scl high); bus pins decode from registered state only.
//
// state | meaning
// IDLE  | bus free (scl=1, sda=1), ready to accept start
// START | start condition, then scl pulled low
// ADDR  | seven address bits, MSB first
// RW    | read/write bit
// WACK  | slave acknowledge of address
// DATA  | eight data bits, driven (write) or sampled (read)
// WACK2 | data acknowledge: released on write, master NACK on read
// STOP  | scl low then high with sda low, ahead of the stop edge
module i2c (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  inout  wire        sda,
  output logic       scl,
  output logic       ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    RW    = 3'd3,
    WACK  = 3'd4,
    DATA  = 3'd5,
    WACK2 = 3'd6,
    STOP  = 3'd7
  } state_t;

  state_t     state;
  logic       phase;
  logic [2:0] bitcnt;
  logic [6:0] addr_q;
  logic [7:0] data_q;
  logic       rw_q;
  logic [7:0] rx_data;
  logic       sda_oe;
  logic       sda_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      bitcnt  <= 3'd0;
      addr_q  <= 7'd0;
      data_q  <= 8'd0;
      rw_q    <= 1'b0;
      rx_data <= 8'd0;
      ready   <= 1'b0;
    end else begin
      phase <= ~phase;
      case (state)
        IDLE: begin
          phase <= 1'b0;
          ready <= 1'b1;
          if (start) begin
            addr_q <= addr;
            data_q <= data;
            rw_q   <= rw;
            state  <= START;
            ready  <= 1'b0;
          end
        end
        START: if (phase) begin
          state  <= ADDR;
          bitcnt <= 3'd6;
        end
        ADDR: if (phase) begin
          if (bitcnt == 3'd0) state <= RW;
          else bitcnt <= bitcnt - 3'd1;
        end
        RW: if (phase) state <= WACK;
        WACK: if (phase) begin
          if (sda == 1'b0) begin
            state  <= DATA;
            bitcnt <= 3'd7;
          end else begin
            state <= STOP;
          end
        end
        DATA: if (phase) begin
          if (rw_q) rx_data <= {rx_data[6:0], sda};
          if (bitcnt == 3'd0) state <= WACK2;
          else bitcnt <= bitcnt - 3'd1;
        end
        WACK2: if (phase) state <= STOP;
        STOP: if (phase) begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // START inverts the slot clock so scl is high first for the start edge.
  always_comb begin
    scl     = 1'b1;
    sda_oe  = 1'b1;
    sda_out = 1'b1;
    case (state)
      IDLE: ;
      START: begin
        scl     = ~phase;
        sda_out = 1'b0;
      end
      ADDR: begin
        scl     = phase;
        sda_out = addr_q[bitcnt];
      end
      RW: begin
        scl     = phase;
        sda_out = rw_q;
      end
      WACK: begin
        scl    = phase;
        sda_oe = 1'b0;
      end
      DATA: begin
        scl = phase;
        if (rw_q) sda_oe = 1'b0;
        else sda_out = data_q[bitcnt];
      end
      WACK2: begin
        scl    = phase;
        sda_oe = rw_q;
      end
      STOP: begin
        scl     = phase;
        sda_out = 1'b0;
      end
    endcase
  end

  assign sda = sda_oe ? sda_out : 1'bz;

endmodule

// File: tb/tb_i2c.sv
// Bench for the i2c master: bus monitor decodes start/stop/bit events and checks them
// against a queue of expected events pushed when each transaction is launched.
module tb_i2c;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] data;
  wire        sda;
  logic       scl;
  logic       ready;

  logic       slave_pull;
  logic       ack_en;
  logic       rd_mode;
  logic [7:0] rd_byte;
  logic [2:0] rd_idx = 3'd7;
  logic       mon_en = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       cur_scl;
  logic       cur_sda;
  int         ev;
  int         exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  wire        sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

  localparam int EV_START = 2;
  localparam int EV_STOP  = 3;

  pullup (sda);
  assign sda = slave_pull ? 1'b0 : 1'bz;

  i2c dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .data  (data),
    .sda   (sda),
    .scl   (scl),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // Open-drain slave: ACKs address in WACK, and in read mode supplies rd_byte MSB first.
  always @(posedge clk) begin
    if (dut.state != 3'd5) rd_idx <= 3'd7;
    else if (scl) rd_idx <= rd_idx - 3'd1;
  end
  assign slave_pull = (dut.state == 3'd4 && ack_en) ||
                      (dut.state == 3'd5 && rd_mode && !rd_byte[rd_idx]);

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cur_scl = scl;
    cur_sda = sda_v;
    if (mon_en) begin
      ev = -1;
      if (prev_scl && cur_scl && prev_sda && !cur_sda) ev = EV_START;
      else if (prev_scl && cur_scl && !prev_sda && cur_sda) ev = EV_STOP;
      else if (!prev_scl && cur_scl) ev = int'(cur_sda);
      if (ev >= 0) begin
        if (exp_q.size() == 0) chk("bus_extra", ev, -1);
        else chk("bus_event", ev, exp_q.pop_front());
      end
    end
    prev_scl = cur_scl;
    prev_sda = cur_sda;
  end

  task automatic push_txn(input logic rw_i, input logic [6:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input logic ack_i);
    exp_q.push_back(EV_START);
    for (int i = 6; i >= 0; i--) exp_q.push_back(int'(a[i]));
    exp_q.push_back(int'(rw_i));
    exp_q.push_back(ack_i ? 0 : 1);
    if (ack_i) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(rw_i ? int'(rd[i]) : int'(wd[i]));
      exp_q.push_back(1);
    end
    exp_q.push_back(0);  // scl rise of the STOP slot, sda still low
    exp_q.push_back(EV_STOP);
  endtask

  task automatic wait_ready(input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
    chk(tag, n, exp_cyc);
  endtask

  task automatic run_txn(input logic rw_i, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input logic ack_i, input int exp_cyc,
                         input string tag);
    int n;
    push_txn(rw_i, a, wd, rd, ack_i);
    ack_en  = ack_i;
    rd_mode = rw_i;
    rd_byte = rd;
    @(negedge clk);
    rw = rw_i; addr = a; data = wd; start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ready_drop"}, int'(ready), 0);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 4) start = 1'b0;
      if (ready) break;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, n, exp_cyc);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_events_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'd0; data = 8'd0;
    ack_en = 1'b0; rd_mode = 1'b0; rd_byte = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(dut.state), 0);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda_v), 1);
    chk("rst_ready", int'(ready), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(ready), 1);
    mon_en = 1'b1;

    run_txn(1'b0, 7'h50, 8'h55, 8'h00, 1'b1, 40, "wr_ack");
    run_txn(1'b0, 7'h50, 8'h55, 8'h00, 1'b0, 22, "wr_nack");
    run_txn(1'b1, 7'h50, 8'h3C, 8'hA5, 1'b1, 40, "rd_ack");
    chk("rd_rx_data", int'(dut.rx_data), 8'hA5);

    // Back-to-back writes with start held high.
    push_txn(1'b0, 7'h2A, 8'hC3, 8'h00, 1'b1);
    push_txn(1'b0, 7'h2A, 8'hC3, 8'h00, 1'b1);
    ack_en = 1'b1; rd_mode = 1'b0;
    @(negedge clk);
    rw = 1'b0; addr = 7'h2A; data = 8'hC3; start = 1'b1;
    @(posedge clk);
    #1;
    wait_ready(40, "b2b_first_cycles");
    chk("b2b_idle_state", int'(dut.state), 0);
    @(posedge clk);
    #1;
    chk("b2b_relaunch_ready", int'(ready), 0);
    chk("b2b_relaunch_state", int'(dut.state), 1);
    start = 1'b0;
    wait_ready(40, "b2b_second_cycles");
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_events_left", exp_q.size(), 0);
    chk("rx_hold_after_write", int'(dut.rx_data), 8'hA5);

    // Reset in the middle of a write data byte.
    mon_en = 1'b0;
    @(negedge clk);
    rw = 1'b0; addr = 7'h50; data = 8'h55; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dut.state == 3'd5 && scl == 1'b0) break;
    end
    chk("mid_data_reached", int'(dut.state), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_state", int'(dut.state), 0);
    chk("mid_rst_scl", int'(scl), 1);
    chk("mid_rst_sda", int'(sda_v), 1);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_rx_data", int'(dut.rx_data), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_after", int'(ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c.md
I2C -- requirements
Module: i2c

Interface
REQ-001 No parameters; the block is a fixed single-byte I2C master.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  transaction request, level-sampled only in IDLE.
REQ-005 rw  input  1  0 = write data byte, 1 = read byte; latched at start.
REQ-006 addr  input  7  7-bit slave address; latched at start.
REQ-007 data  input  8  byte to write; latched at start.
REQ-008 sda  inout  1  I2C data; driven 0/1 when master owns the line, high-Z when released.
REQ-009 scl  output  1  I2C clock.
REQ-010 ready  output  1  high when idle and able to accept start.

Function
REQ-011 The FSM register SHALL be named state, 3 bits, encoded IDLE=0, START=1, ADDR=2, RW=3, WACK=4, DATA=5, WACK2=6, STOP=7.
REQ-012 Each bit slot SHALL take 2 clk cycles: phase0 scl=0 (sda changes), phase1 scl=1 (sda stable/sampled).
REQ-013 scl/sda drive SHALL be decoded only from registered state/phase/bit-count; no combinational path from inputs.
REQ-014 IDLE: scl=1, sda driven 1, ready=1; on start=1 latch addr/rw/data and go START; ready=0 from the next cycle.
REQ-015 START (2 cycles): cycle0 scl=1 sda=0 (start condition), cycle1 scl=0 sda=0; then ADDR with bit index 6.
REQ-016 ADDR: 7 slots, addr[6] first (MSB first), sda=latched addr bit; after bit 0 go RW.
REQ-017 RW: one slot with sda=latched rw; then WACK.
REQ-018 WACK: sda released (high-Z) for its full slot; sda sampled in phase1; sampled 0 = ACK -> DATA (bit index 7), anything else = NACK -> STOP.
REQ-019 DATA, rw=0: 8 slots driving data[7..0] MSB first; rw=1: sda released, sda sampled in each phase1 and shifted MSB-first into an internal 8-bit register rx_data.
REQ-020 WACK2: rw=0 sda released, sampled value ignored; rw=1 master drives sda=1 (NACK); then STOP unconditionally.
REQ-021 STOP (2 cycles): cycle0 scl=0 sda=0, cycle1 scl=1 sda=0; then IDLE, whose sda=1 with scl=1 forms the stop condition.
REQ-022 Full ACKed transaction: 40 cycles from the start-sampling edge to re-entering IDLE; start is ignored outside IDLE.
REQ-023 start still high on IDLE re-entry SHALL launch a new transaction after exactly one IDLE cycle.
REQ-024 rx_data SHALL hold its value until the next read transaction overwrites it.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, phase and bit counters=0, latched registers and rx_data=0, from any state including mid-transfer.
REQ-026 While rst=1: scl=1, sda driven 1, ready=0; ready=1 on the first edge after rst deasserts.
REQ-027 rst has priority over start on the same edge.

Verification
REQ-028 Write with ACK: addr=0x50, data=0x55, rw=0, slave pulls sda low only in state 4, start for 5 cycles -> start condition, sda bits 1,0,1,0,0,0,0 then rw 0, data 0,1,0,1,0,1,0,1, stop condition; ready=1 40 cycles after start sampled.
REQ-029 NACK: same stimulus, no slave drive (sda not 0 in WACK) -> no DATA state; STOP follows WACK; ready=1 22 cycles after start sampled.
REQ-030 Read: addr=0x50, rw=1, slave ACKs, then drives 0xA5 MSB-first in DATA -> rx_data=0xA5, master sda=1 in WACK2, stop condition.
REQ-031 Reset mid-DATA: rst=1 for 1 cycle -> next cycle state=0, scl=1, sda=1, ready=0; ready=1 after rst drops; no stop condition.
REQ-032 start held high continuously -> back-to-back transactions, each separated by exactly one IDLE cycle with ready=1.
